// File: rtl/rega_pkg.sv
// rtl/rega_pkg.sv - shared types and constants for the watering-cycle controller
package rega_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WATER = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest legal BCD digit
    localparam logic [3:0] BCD_MAX = 4'd9;

    // One Tick pulse represents this many milliseconds of watering
    localparam int TICK_UNIT_MS = 1000;

    // A programmed duration is usable when both digits are BCD and it is not 00
    function automatic logic dur_valid(input logic [3:0] t, input logic [3:0] u);
        return (t <= BCD_MAX) && (u <= BCD_MAX) && ({t, u} != 8'h00);
    endfunction

endpackage

// File: rtl/rega_if.sv
// rtl/rega_if.sv - panel/sensor inputs and valve/display outputs of the controller
//   slave  : controller side (sensors and panel in, valve/status/count out)
//   master : environment side (drives sensors and panel, observes outputs)
interface rega_if;
    logic       Tick;
    logic       Start;
    logic       Stop;
    logic       Dry;
    logic       Rain;
    logic [3:0] Dur_T;
    logic [3:0] Dur_U;
    logic       Valve;
    logic       Busy;
    logic       Done;
    logic       Err;
    logic [3:0] Cnt_T;
    logic [3:0] Cnt_U;

    modport slave (
        input  Tick, Start, Stop, Dry, Rain, Dur_T, Dur_U,
        output Valve, Busy, Done, Err, Cnt_T, Cnt_U
    );

    modport master (
        output Tick, Start, Stop, Dry, Rain, Dur_T, Dur_U,
        input  Valve, Busy, Done, Err, Cnt_T, Cnt_U
    );
endinterface

// File: rtl/rega_ctrl_cnt.sv
// rtl/rega_ctrl_cnt.sv - two-digit BCD down-counter with load, clear and enable
//   Clk, Rst_n       : clock, async active-low reset (count -> 00)
//   clr, load, en    : synchronous controls, priority clr > load > en
//   load_t, load_u   : value loaded on load
//   cnt_t, cnt_u     : current count (tens, units)
//   zero, one        : count == 00 / count == 01
module bcd_down_cnt2
    import rega_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_t,
    input  logic [3:0] load_u,
    output logic [3:0] cnt_t,
    output logic [3:0] cnt_u,
    output logic       zero,
    output logic       one
);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_t <= 4'd0;
            cnt_u <= 4'd0;
        end else if (clr) begin
            cnt_t <= 4'd0;
            cnt_u <= 4'd0;
        end else if (load) begin
            cnt_t <= load_t;
            cnt_u <= load_u;
        end else if (en && !zero) begin
            // Units borrow from tens; guarded so 00 never wraps to 99
            if (cnt_u == 4'd0) begin
                cnt_u <= BCD_MAX;
                cnt_t <= cnt_t - 4'd1;
            end else begin
                cnt_u <= cnt_u - 4'd1;
            end
        end
    end

    assign zero = (cnt_t == 4'd0) && (cnt_u == 4'd0);
    assign one  = (cnt_t == 4'd0) && (cnt_u == 4'd1);

endmodule

// File: rtl/rega_ctrl.sv
// rtl/rega_ctrl.sv - watering-cycle controller: FSM, valve drive, BCD run timer
//   Clk, Rst_n : clock, async active-low reset
//   bus        : rega_if.slave (Tick/Start/Stop/Dry/Rain/Dur_* in;
//                Valve/Busy/Done/Err/Cnt_* out, all registered)
module rega_ctrl
    import rega_pkg::*;
(
    input  logic  Clk,
    input  logic  Rst_n,
    rega_if.slave bus
);

    state_t state, next;
    logic   cnt_load, cnt_clr, cnt_en, err_next;
    logic   cnt_zero, cnt_one;
    logic   valve_q, busy_q, done_q, err_q;
    logic   start_ok;

    // Start is acted on only when nothing blocks it
    assign start_ok = bus.Start && !bus.Stop && bus.Dry && !bus.Rain;

    bcd_down_cnt2 u_cnt (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .clr    (cnt_clr),
        .load   (cnt_load),
        .en     (cnt_en),
        .load_t (bus.Dur_T),
        .load_u (bus.Dur_U),
        .cnt_t  (bus.Cnt_T),
        .cnt_u  (bus.Cnt_U),
        .zero   (cnt_zero),
        .one    (cnt_one)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next     = state;
        cnt_load = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        err_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    if (dur_valid(bus.Dur_T, bus.Dur_U)) begin
                        cnt_load = 1'b1;
                        next     = WATER;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            WATER: begin
                // Stop beats Rain beats Tick
                if (bus.Stop) begin
                    cnt_clr = 1'b1;
                    next    = IDLE;
                end else if (bus.Rain) begin
                    next = PAUSE;
                end else if (bus.Tick && !cnt_zero) begin
                    cnt_en = 1'b1;
                    if (cnt_one) next = DONE;
                end
            end
            PAUSE: begin
                if (bus.Stop) begin
                    cnt_clr = 1'b1;
                    next    = IDLE;
                end else if (!bus.Rain) begin
                    next = WATER;
                end
            end
            DONE: begin
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valve_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valve_q <= (next == WATER);
            busy_q  <= (next == WATER) || (next == PAUSE);
            done_q  <= (next == DONE);
            err_q   <= err_next;
        end
    end

    assign bus.Valve = valve_q;
    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
    assign bus.Err   = err_q;

endmodule

// File: tb/tb_rega_ctrl.sv
// tb/tb_rega_ctrl.sv - self-checking bench for rega_ctrl
module tb_rega_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    rega_if bus ();

    rega_ctrl dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       start;
        logic       stop;
        logic       dry;
        logic       rain;
        logic [3:0] dt;
        logic [3:0] du;
        logic [11:0] exp;   // {valve, busy, done, err, cnt_t, cnt_u}
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic tick, input logic start, input logic stop,
                                input logic dry, input logic rain,
                                input logic [3:0] dt, input logic [3:0] du,
                                input logic valve, input logic busy, input logic done,
                                input logic err, input logic [3:0] ct, input logic [3:0] cu);
        vec_t v;
        v.tick  = tick;
        v.start = start;
        v.stop  = stop;
        v.dry   = dry;
        v.rain  = rain;
        v.dt    = dt;
        v.du    = du;
        v.exp   = {valve, busy, done, err, ct, cu};
        vecs.push_back(v);
    endfunction

    function automatic logic [11:0] outs();
        return {bus.Valve, bus.Busy, bus.Done, bus.Err, bus.Cnt_T, bus.Cnt_U};
    endfunction

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got valve/busy/done/err/cnt=%b %b %b %b %h%h, want %b %b %b %b %h%h",
                     name, got[11], got[10], got[9], got[8], got[7:4], got[3:0],
                     exp[11], exp[10], exp[9], exp[8], exp[7:4], exp[3:0]);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.Tick  = v.tick;
        bus.Start = v.start;
        bus.Stop  = v.stop;
        bus.Dry   = v.dry;
        bus.Rain  = v.rain;
        bus.Dur_T = v.dt;
        bus.Dur_U = v.du;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.Tick = 1'b0; bus.Start = 1'b0; bus.Stop = 1'b0;
        bus.Dry  = 1'b1; bus.Rain  = 1'b0;
        bus.Dur_T = 4'd0; bus.Dur_U = 4'd0;

        // Dur=12 full run
        add(0,1,0,1,0, 1,2, 1,1,0,0, 1,2);
        for (int i = 11; i >= 1; i--)
            add(1,0,0,1,0, 1,2, 1,1,0,0, 4'(i / 10), 4'(i % 10));
        add(1,0,0,1,0, 1,2, 0,0,1,0, 0,0);
        add(0,0,0,1,0, 1,2, 0,0,0,0, 0,0);
        // Dur=30 borrow, then stop; invalid durations
        add(0,1,0,1,0, 3,0, 1,1,0,0, 3,0);
        add(1,0,0,1,0, 3,0, 1,1,0,0, 2,9);
        add(0,0,1,1,0, 3,0, 0,0,0,0, 0,0);
        add(0,1,0,1,0, 1,4'hA, 0,0,0,1, 0,0);
        add(0,0,0,1,0, 1,4'hA, 0,0,0,0, 0,0);
        add(0,1,0,1,0, 0,0, 0,0,0,1, 0,0);
        add(0,0,0,1,0, 0,0, 0,0,0,0, 0,0);
        // Dur=05 with rain pause
        add(0,1,0,1,0, 0,5, 1,1,0,0, 0,5);
        add(1,0,0,1,0, 0,5, 1,1,0,0, 0,4);
        add(1,0,0,1,0, 0,5, 1,1,0,0, 0,3);
        add(1,0,0,1,1, 0,5, 0,1,0,0, 0,3);
        for (int i = 0; i < 3; i++)
            add(1,0,0,1,1, 0,5, 0,1,0,0, 0,3);
        add(0,0,0,1,0, 0,5, 1,1,0,0, 0,3);
        add(1,0,0,0,0, 0,5, 1,1,0,0, 0,2);
        add(1,0,0,0,0, 0,5, 1,1,0,0, 0,1);
        add(1,0,0,1,0, 0,5, 0,0,1,0, 0,0);
        add(0,0,0,1,0, 0,5, 0,0,0,0, 0,0);
        // Dur=50, 10 ticks, stop with tick; start+stop blocked
        add(0,1,0,1,0, 5,0, 1,1,0,0, 5,0);
        for (int i = 49; i >= 40; i--)
            add(1,0,0,1,0, 5,0, 1,1,0,0, 4'(i / 10), 4'(i % 10));
        add(1,0,1,1,0, 5,0, 0,0,0,0, 0,0);
        add(0,0,0,1,0, 5,0, 0,0,0,0, 0,0);
        add(0,1,1,1,0, 5,0, 0,0,0,0, 0,0);
        // Start gated by sensors, silently even with bad duration
        add(0,1,0,0,0, 1,2, 0,0,0,0, 0,0);
        add(0,1,0,1,1, 1,2, 0,0,0,0, 0,0);
        add(0,1,0,0,0, 0,0, 0,0,0,0, 0,0);
        // Start held: DONE ignores it, IDLE restarts
        add(0,1,0,1,0, 0,2, 1,1,0,0, 0,2);
        add(1,1,0,1,0, 0,2, 1,1,0,0, 0,1);
        add(1,1,0,1,0, 0,2, 0,0,1,0, 0,0);
        add(0,1,0,1,0, 0,2, 0,0,0,0, 0,0);
        add(0,1,0,1,0, 0,2, 1,1,0,0, 0,2);
        add(0,0,1,1,0, 0,2, 0,0,0,0, 0,0);
        // Stop during pause
        add(0,1,0,1,0, 0,3, 1,1,0,0, 0,3);
        add(0,0,0,1,1, 0,3, 0,1,0,0, 0,3);
        add(0,0,1,1,1, 0,3, 0,0,0,0, 0,0);
        add(0,0,0,1,0, 0,3, 0,0,0,0, 0,0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), 12'h000);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Asynchronous reset mid-run at Cnt=07
        drive('{tick:0, start:1, stop:0, dry:1, rain:0, dt:4'd0, du:4'd9, exp:12'h0});
        @(posedge clk); #1;
        bus.Start = 1'b0;
        bus.Tick  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.Tick = 1'b0;
        check("pre_reset_cnt07", outs(), 12'hC07);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_no_edge", outs(), 12'h000);
        @(posedge clk); #1;
        check("reset_held", outs(), 12'h000);
        #2;
        rst_n = 1'b1;
        bus.Start = 1'b1;
        bus.Dur_T = 4'd0;
        bus.Dur_U = 4'd3;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        check("restart_after_reset", outs(), 12'hC03);
        bus.Tick = 1'b1;
        @(posedge clk); #1;
        bus.Tick = 1'b0;
        check("tick_after_reset", outs(), 12'hC02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
